// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes core accesses into lane-aligned word requests
// for a simple req/ack memory, then returns extended load data or an error.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] busy_cnt;
    logic          lat_we;
    logic [2:0]    lat_funct3;
    logic [1:0]    lat_off;

    logic          req_legal;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;
    logic [31:0]   shifted;
    logic [7:0]    lane_byte;
    logic [15:0]   lane_half;
    logic [31:0]   load_data;

    assign req_ready = (state == IDLE);

    // Legality, byte enables and lane replication for the access on the request port
    always_comb begin
        req_legal = 1'b0;
        unique case (funct3)
            3'b000:  req_legal = 1'b1;
            3'b001:  req_legal = ~addr[0];
            3'b010:  req_legal = (addr[1:0] == 2'b00);
            3'b100:  req_legal = ~req_we;
            3'b101:  req_legal = ~req_we & ~addr[0];
            default: req_legal = 1'b0;
        endcase

        be_next    = 4'b1111;
        wdata_next = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        shifted   = mem_rdata >> {lat_off, 3'b000};
        lane_byte = shifted[7:0];
        lane_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = '0;
        unique case (lat_funct3)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {24'b0, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_data = {16'b0, lane_half};
            3'b010:  load_data = mem_rdata;
            default: load_data = '0;
        endcase
        if (lat_we) begin
            load_data = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy_cnt   <= '0;
            lat_we     <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_off    <= 2'b00;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    rdata      <= '0;
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_funct3 <= funct3;
                        lat_off    <= addr[1:0];
                        busy_cnt   <= '0;
                        if (req_legal) begin
                            state     <= BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                // Ack wins over a timeout that expires on the same edge
                BUSY: begin
                    if (mem_ack) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        rdata      <= load_data;
                    end else if (busy_cnt == CW'(TIMEOUT - 1)) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        rdata      <= '0;
                    end else begin
                        busy_cnt <= busy_cnt + CW'(1);
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    rdata      <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles mem_req is held without mem_ack before the access is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, core presents an access.
REQ-005 SHALL have port req_ready, output, 1, unit can accept an access.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port funct3, input, 3, RV32I width/sign code.
REQ-008 SHALL have port addr, input, 32, byte address, which is the ALU result.
REQ-009 SHALL have port wdata, input, 32, store data, taken from rs2.
REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resp_err, output, 1, completion is an error; valid only with resp_valid.
REQ-012 SHALL have port rdata, output, 32, extended load data; valid only with resp_valid on a load.
REQ-013 SHALL have port mem_req, output, 1, memory request.
REQ-014 SHALL have port mem_we, output, 1, memory write.
REQ-015 SHALL have port mem_addr, output, 32, word address with bits [1:0] = 00.
REQ-016 SHALL have port mem_be, output, 4, byte enables; bit i selects byte lane i.
REQ-017 SHALL have port mem_wdata, output, 32, lane-aligned store data.
REQ-018 SHALL have port mem_ack, input, 1, memory completion.
REQ-019 SHALL have port mem_rdata, input, 32, read word; sampled when mem_ack = 1.

Function
REQ-020 SHALL implement a state machine with states IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 SHALL accept an access on a rising edge where req_valid = 1 and req_ready = 1, and SHALL latch req_we, funct3, addr and wdata on that edge.
REQ-022 SHALL treat the following as legal: loads with funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores with funct3 000 SB, 001 SH, 010 SW.
REQ-023 SHALL treat any other funct3, and any misaligned address (halfword with addr[0] = 1; word with addr[1:0] != 00), as an error access.
REQ-024 SHALL, on an error access, go IDLE -> RESP without asserting mem_req, and SHALL then output resp_valid = 1 and resp_err = 1 for one cycle.
REQ-025 SHALL, on a legal access, go IDLE -> BUSY; in BUSY, mem_req SHALL be 1 and mem_addr, mem_we, mem_be and mem_wdata SHALL be stable.
REQ-026 SHALL drive mem_be as follows: byte access 0001 shifted left by addr[1:0]; halfword access 0011 or 1100, selected by addr[1]; word access 1111.
REQ-027 SHALL drive mem_wdata as follows: byte stores replicate wdata[7:0] into all four lanes; halfword stores replicate wdata[15:0] into both halves; word stores use wdata unchanged.
REQ-028 SHALL, on an edge in BUSY where mem_ack = 1, capture mem_rdata, go to RESP, and deassert mem_req in the next cycle.
REQ-029 SHALL form rdata by selecting the addressed lane and then extending: LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged; rdata SHALL be 0 for stores and errors.
REQ-030 SHALL hold RESP for exactly one cycle with resp_valid = 1, and SHALL then return to IDLE.
REQ-031 SHALL count BUSY cycles and, if mem_ack has not arrived after TIMEOUT BUSY cycles, go to RESP with resp_err = 1 and drop mem_req.
REQ-032 SHALL ignore mem_ack received outside BUSY.
REQ-033 SHALL, for a legal access accepted at edge N with mem_ack high during the first BUSY cycle, assert resp_valid in cycle N+2.
REQ-034 SHALL sustain a back-to-back throughput of one access per 3 cycles.
REQ-035 SHALL NOT accept a new request in RESP, even if req_valid = 1.

Reset
REQ-036 SHALL, when rst_n = 0 and regardless of clk, force the state to IDLE, clear the timeout counter and all latched fields, and drive mem_req = 0, resp_valid = 0, resp_err = 0, rdata = 0, mem_we = 0, mem_be = 0000, mem_addr = 0 and mem_wdata = 0.
REQ-037 SHALL, on reset during BUSY, abandon the access with no response, and SHALL drive req_ready = 1 from the first edge after rst_n rises.

Verification
REQ-038 SHALL be verified by this scenario: LW addr = 0x100, mem_ack in the first BUSY cycle, mem_rdata = 0xDEADBEEF -> mem_addr = 0x100, mem_be = 1111, then resp_valid = 1, resp_err = 0, rdata = 0xDEADBEEF.
REQ-039 SHALL be verified by this scenario: LB addr = 0x103, mem_rdata = 0x80123456 -> mem_be = 1000, rdata = 0xFFFFFF80; the same access as LBU -> rdata = 0x00000080.
REQ-040 SHALL be verified by this scenario: SH addr = 0x22, wdata = 0x1234ABCD -> mem_addr = 0x20, mem_be = 1100, mem_wdata = 0xABCDABCD, mem_we = 1, then resp_err = 0.
REQ-041 SHALL be verified by this scenario: LW addr = 0x102 -> mem_req stays 0; one cycle later resp_valid = 1, resp_err = 1; funct3 = 011 -> the same response.
REQ-042 SHALL be verified by this scenario: LW with mem_ack held 0 and TIMEOUT = 16 -> mem_req = 1 for 16 cycles, then resp_err = 1 and IDLE.
REQ-043 SHALL be verified by this scenario: rst_n pulled low in the 3rd BUSY cycle -> mem_req = 0 immediately, no resp_valid, and a following LW completes normally.
